// File: rtl/cic_interp_osr.sv
// rtl/cic_interp_osr.sv - 3-stage CIC interpolator, runtime rate R = osr+1, valid/ready sample input.
// Optional CIC_INTERP_ROUND_EN: round half-up before the output shift instead of truncating.
module cic_interp_osr #(
    parameter int DATA_WIDTH = 10,
    parameter int OSR_WIDTH  = 7,
    parameter int RES_WIDTH  = DATA_WIDTH,
    parameter int WIDTH      = 3*OSR_WIDTH+DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  sclr,
    input  logic                  clock_ena,
    input  logic [OSR_WIDTH-1:0]  osr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [RES_WIDTH-1:0]  res,
    output logic                  valid,
    output logic                  underrun
);

    localparam int SHIFT = 2*OSR_WIDTH;

    logic [OSR_WIDTH-1:0]  phase_q, phase_d;
    logic [OSR_WIDTH-1:0]  osr_q, osr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [WIDTH-1:0]      xdly_q, xdly_d;
    logic [WIDTH-1:0]      c1dly_q, c1dly_d;
    logic [WIDTH-1:0]      c2dly_q, c2dly_d;
    logic [WIDTH-1:0]      c3_q, c3_d;
    logic                  fresh_q, fresh_d;
    logic [WIDTH-1:0]      i1_q, i1_d;
    logic [WIDTH-1:0]      i2_q, i2_d;
    logic [WIDTH-1:0]      i3_q, i3_d;
    logic [RES_WIDTH-1:0]  res_q, res_d;
    logic                  valid_q, valid_d;
    logic                  underrun_q, underrun_d;

    logic                  frame_start;
    logic [WIDTH-1:0]      x_sel;
    logic [WIDTH-1:0]      c1;
    logic [WIDTH-1:0]      c2;
    logic [WIDTH-1:0]      c3;
    logic [WIDTH-1:0]      u;

    assign frame_start = clock_ena && (phase_q == '0);
    // An empty hold register at frame start repeats the previous sample.
    assign x_sel = hold_full_q ? {{(WIDTH-DATA_WIDTH){hold_q[DATA_WIDTH-1]}}, hold_q} : xdly_q;
    assign c1    = x_sel - xdly_q;
    assign c2    = c1 - c1dly_q;
    assign c3    = c2 - c2dly_q;
    assign u     = fresh_q ? c3_q : '0;

    always_comb begin
        phase_d     = phase_q;
        osr_d       = osr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        xdly_d      = xdly_q;
        c1dly_d     = c1dly_q;
        c2dly_d     = c2dly_q;
        c3_d        = c3_q;
        fresh_d     = fresh_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        res_d       = res_q;
        valid_d     = 1'b0;
        underrun_d  = underrun_q;

        if (clock_ena) begin
            i1_d    = i1_q + u;
            i2_d    = i2_q + i1_q;
            i3_d    = i3_q + i2_q;
            fresh_d = frame_start;
            valid_d = 1'b1;
`ifdef CIC_INTERP_ROUND_EN
            // (i3 + 2**(SHIFT-1)) >> SHIFT == (i3 >> SHIFT) + i3[SHIFT-1]
            res_d = i3_d[SHIFT +: RES_WIDTH] + {{(RES_WIDTH-1){1'b0}}, i3_d[SHIFT-1]};
`else
            res_d = i3_d[SHIFT +: RES_WIDTH];
`endif
            if (frame_start) begin
                osr_d       = osr;
                phase_d     = (osr == '0) ? '0 : {{(OSR_WIDTH-1){1'b0}}, 1'b1};
                xdly_d      = x_sel;
                c1dly_d     = c1;
                c2dly_d     = c2;
                c3_d        = c3;
                hold_full_d = 1'b0;
                if (!hold_full_q) begin
                    underrun_d = 1'b1;
                end
            end else begin
                phase_d = (phase_q == osr_q) ? '0 : phase_q + {{(OSR_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        // Load only while empty, so it never collides with a consume.
        if (in_valid && !hold_full_q) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n || sclr) begin
            phase_q     <= '0;
            osr_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            xdly_q      <= '0;
            c1dly_q     <= '0;
            c2dly_q     <= '0;
            c3_q        <= '0;
            fresh_q     <= 1'b0;
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            res_q       <= '0;
            valid_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            osr_q       <= osr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            xdly_q      <= xdly_d;
            c1dly_q     <= c1dly_d;
            c2dly_q     <= c2dly_d;
            c3_q        <= c3_d;
            fresh_q     <= fresh_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            res_q       <= res_d;
            valid_q     <= valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign res      = res_q;
    assign valid    = valid_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_cic_interp_osr.sv
// tb/tb_cic_interp_osr.sv - scoreboard bench for cic_interp_osr with directed vectors.
module tb_cic_interp_osr;

    logic       clock;
    logic       aclr_n;
    logic       sclr;
    logic       clock_ena;
    logic [6:0] osr;
    logic [9:0] data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] res;
    logic       valid;
    logic       underrun;

    cic_interp_osr dut (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .clock_ena (clock_ena),
        .osr       (osr),
        .data      (data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .valid     (valid),
        .underrun  (underrun)
    );

    typedef struct {
        bit chk;
        int val;
        int test;
        int idx;
    } exp_t;

    exp_t sb_q[$];
    int   hs_q[$];
    int   tick_cnt = 0;
    int   cur_test = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t e;
    int   act;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every valid pulse is matched against the oldest expected entry.
    always @(negedge clock) begin
        if (valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_valid: res=%0d with no expected entry", $signed(res));
            end else begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    act = int'($signed(res));
                    n_cmp++;
                    if (act != e.val) begin
                        n_bad++;
                        $display("FAIL res t%0d tick %0d: got %0d expected %0d", e.test, e.idx, act, e.val);
                    end
                end
            end
        end
    end

    always @(posedge clock) begin
        if (aclr_n && !sclr && in_valid && in_ready) hs_q.push_back(tick_cnt);
    end

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick(input bit chk, input int val);
        repeat (2) @(negedge clock);
        sb_q.push_back('{chk, val, cur_test, tick_cnt});
        clock_ena = 1'b1;
        @(negedge clock);
        clock_ena = 1'b0;
        tick_cnt++;
    endtask

    task automatic drain(input string nm);
        repeat (2) @(negedge clock);
        check(nm, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_reset(input int o, input int d, input bit v);
        clock_ena = 1'b0;
        sclr      = 1'b0;
        drain("sb_drain");
        aclr_n   = 1'b0;
        osr      = 7'(o);
        data     = 10'(d);
        in_valid = v;
        @(negedge clock);
        hs_q.delete();
        tick_cnt = 0;
        aclr_n   = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr_n = 1'b0; sclr = 1'b0; clock_ena = 1'b0;
        osr = '0; data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_res", int'($signed(res)), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_underrun", int'(underrun), 0);

        // DC 100 at R=128: gain exactly 1, one handshake per frame.
        cur_test = 1;
        do_reset(127, 100, 1'b1);
        for (int i = 0; i < 512; i++) tick((i <= 3) || (i >= 400), (i <= 3) ? 0 : 100);
        @(negedge clock);
        check("dc_hs_count", hs_q.size(), 5);
        check("dc_hs_gap", hs_q[3] - hs_q[2], 128);

        // DC -512: first movement three ticks after frame start (floor(-512/2**14) = -1).
        cur_test = 2;
        do_reset(127, -512, 1'b1);
        for (int i = 0; i < 450; i++) tick((i <= 3) || (i >= 400), (i < 3) ? 0 : ((i == 3) ? -1 : -512));

        // R=64, data 400 -> 100; osr changed mid-frame only affects the next frame.
        cur_test = 3;
        do_reset(63, 400, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) osr = 7'd127;
            tick((i <= 3) || (i >= 260), (i <= 3) ? 0 : 100);
        end
        @(negedge clock);
        check("rate_hs_count", hs_q.size(), 9);
        check("rate_old_frame_len", hs_q[6] - hs_q[5], 64);
        check("rate_new_frame_len", hs_q[7] - hs_q[6], 128);

        // Underrun: no sample for frame starting at tick 768.
        cur_test = 4;
        do_reset(127, 100, 1'b1);
        for (int i = 0; i < 900; i++) begin
            if (i == 520) in_valid = 1'b0;
            if (i == 600) check("ur_hold_full", int'(in_ready), 0);
            if (i == 700) check("ur_hold_empty", int'(in_ready), 1);
            if (i == 760) check("ur_before", int'(underrun), 0);
            if (i == 780) begin
                check("ur_set", int'(underrun), 1);
                in_valid = 1'b1;
            end
            tick(i >= 400, 100);
        end
        check("ur_sticky", int'(underrun), 1);

        // Asynchronous reset mid-frame with integrators loaded.
        cur_test = 5;
        drain("sb_drain_areset");
        @(posedge clock);
        #2;
        aclr_n = 1'b0;
        #1;
        check("areset_res", int'($signed(res)), 0);
        check("areset_valid", int'(valid), 0);
        check("areset_underrun", int'(underrun), 0);
        check("areset_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clock);
        hs_q.delete();
        tick_cnt = 0;
        aclr_n = 1'b1;
        #1;
        check("arel_in_ready", int'(in_ready), 1);
        check("arel_res", int'($signed(res)), 0);
        for (int i = 0; i < 140; i++) tick(i <= 3, 0);
        @(negedge clock);
        check("arel_hs_count", hs_q.size(), 3);
        check("arel_first_frame", hs_q[1], 1);
        check("arel_second_frame", hs_q[2], 129);

        // Synchronous clear: takes effect at the next edge.
        cur_test = 6;
        drain("sb_drain_sclr");
        sclr = 1'b1;
        #1;
        check("sclr_pre_in_ready", int'(in_ready), 0);
        @(negedge clock);
        check("sclr_res", int'($signed(res)), 0);
        check("sclr_valid", int'(valid), 0);
        check("sclr_in_ready", int'(in_ready), 1);
        check("sclr_underrun", int'(underrun), 0);
        hs_q.delete();
        tick_cnt = 0;
        sclr = 1'b0;
        for (int i = 0; i < 140; i++) tick(i <= 3, 0);
        @(negedge clock);
        check("srel_hs_count", hs_q.size(), 3);
        check("srel_first_frame", hs_q[1], 1);
        check("srel_second_frame", hs_q[2], 129);

        // Back-pressure: one sample held, no ticks for 50 cycles.
        cur_test = 7;
        do_reset(127, 100, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        check("bp_one_load", hs_q.size(), 1);
        tick(1'b1, 0);
        check("bp_in_ready_rise", int'(in_ready), 1);
        @(negedge clock);
        check("bp_reload", hs_q.size(), 2);
        check("bp_in_ready_refill", int'(in_ready), 0);
        check("bp_underrun", int'(underrun), 0);

        drain("sb_drain_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cic_interp_osr.md
Name: cic_interp_osr

Overview:
- 3-stage CIC interpolator with a runtime-programmable rate R = osr+1, where osr ≤ 2**OSR_WIDTH-1.
- Counterpart of the decimation path. It accepts low-rate samples over a valid/ready handshake and emits one high-rate sample per clock_ena tick.
- Feeds the DAC / modulator chain at the oversampled rate.

Parameters:
- DATA_WIDTH, 10, signed two's-complement input sample width.
- OSR_WIDTH, 7, width of osr; nominal full rate 2**OSR_WIDTH.
- RES_WIDTH, DATA_WIDTH, output sample width.
- WIDTH, 3*OSR_WIDTH+DATA_WIDTH, internal comb/integrator width (modulo-2**WIDTH arithmetic).

Ports:
- clock  in  1  system clock; all registers are on its rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear, active high; same effect as reset.
- clock_ena  in  1  output-rate tick; integrators and the phase counter advance only on ticks.
- osr  in  OSR_WIDTH  rate minus 1; sampled only at frame start.
- data  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  data is valid.
- in_ready  out  1  the block can accept data this cycle.
- res  out  RES_WIDTH  signed interpolated sample.
- valid  out  1  one-cycle pulse when res updates.
- underrun  out  1  sticky flag: a frame started with no sample available.

Behaviour:
- Reset (aclr_n=0 or sclr=1) clears everything to 0: phase, osr_q, hold register, hold_full, comb registers and delays, fresh, integrators, res, valid, underrun. aclr_n takes priority over sclr.
- After reset, in_ready=1.
- Input hold register, one entry:
  - in_ready = !hold_full.
  - Load on in_valid && in_ready, which sets hold_full.
  - No simultaneous consume and load: in_ready is low while the register is full.
- Phase counter (ticks only):
  - A tick with phase==0 is a frame start. osr_q <= osr, and phase becomes (osr==0 ? 0 : 1).
  - Otherwise phase increments and wraps to 0 after reaching osr_q.
  - Changing osr mid-frame has no effect until the next frame start.
- Frame start:
  - x = hold_full ? hold : x_prev. If hold_full=0, set underrun; the previous sample is repeated.
  - Clear hold_full.
  - Comb chain updates combinationally and is registered: c1 = x - x_d, c2 = c1 - c1_d, c3 = c2 - c2_d. The delays take the new values.
  - Set fresh.
- Every tick:
  - u = fresh ? c3_reg : 0 (zero stuffing); fresh is cleared when used.
  - Integrators update from their old values: i1 += u; i2 += i1; i3 += i2. All arithmetic is sign-extended to WIDTH and wraps.
  - Each tick therefore consumes the previous frame's c3_reg. If the same tick sets fresh and reads u, u uses the old fresh value, so u follows one tick later.
- Output:
  - res <= i3 >>> (2*OSR_WIDTH), arithmetic shift, truncating, low RES_WIDTH bits. Registered one cycle after the tick.
  - valid pulses high in the same cycle res updates.
  - DC gain = R²/2**(2*OSR_WIDTH): exactly 1 at R=128.
- Latency: a step at input frame k first moves res three ticks after frame k's start. The step is fully settled 3R ticks later.
- osr=0 (R=1): every tick is a frame start and one sample is consumed per tick. Gain is 1/2**14.
- Boundary conditions:
  - in_valid held without ticks: exactly one sample is held; further data is back-pressured.
  - Reset mid-frame: all state is dropped; the next tick is a frame start.
  - underrun clears only on reset or sclr.

Optional Feature:
- Macro CIC_INTERP_ROUND_EN.
- Defined: round half-up before the shift, res = (i3 + 2**(2*OSR_WIDTH-1)) >>> 2*OSR_WIDTH. No saturation.
- Undefined: plain truncation as above.
- Latency and ports are identical in both builds.

Test Plan:
- DC: osr=127, source always valid with data=100, ticks every 3rd clock. After 400 ticks every res is 100, with exactly one handshake per 128 ticks. Also data=-512 → res=-512.
- Rate/gain: osr=63, data=400 constant → res settles to 100. Change osr to 127 mid-frame → the new frame length is observed only from the next frame start.
- Impulse: osr=127, one sample 512 then zeros. The sequence of i3 values sums to 512·128³. res first nonzero exactly 3 ticks after that frame start; res is 0 again after 3·128 ticks.
- Underrun: osr=127, stop in_valid for one frame → underrun=1 at that frame start, the previous sample is repeated, res stays at the DC value, and the flag stays set.
- Back-pressure: in_valid=1 and clock_ena=0 for 50 cycles → one load, in_ready=0 throughout. The first tick consumes the sample and in_ready rises the next cycle.
- Reset: assert aclr_n=0 mid-frame with integrators nonzero → all outputs 0 immediately. Release → in_ready=1, res=0 and valid=0 until the next tick. Repeat with sclr → same result, one cycle later.
